// File: rtl/cic_gain_ctrl_pkg.sv
// Shared FSM encoding and default gain/threshold constants for the CIC gain controller.
package cic_gain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  localparam int DEF_WINDOW    = 256;
  localparam int DEF_SETTLE    = 8;
  localparam int DEF_GAIN_INIT = 20;
  localparam int DEF_GAIN_MAX  = 40;
  localparam int DEF_HI_THRESH = 1536;
  localparam int DEF_LO_THRESH = 512;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cic_peak_detect.sv
// Strobe detect on data_clk, saturating |data_in|, running peak / full-scale flag and strobe counter.
// Results are registered on the strobe cycle; clear has priority over any strobe in the same cycle.
module cic_peak_detect #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_W      = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_clk,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         clear,
  input  logic                         acc_en,
  input  logic                         cnt_en,
  output logic                         strobe,
  output logic        [DATA_WIDTH-1:0] run_peak,
  output logic                         run_clip,
  output logic        [CNT_W-1:0]      cnt
);

  localparam logic [DATA_WIDTH-1:0] FULL_SCALE = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  data_clk_q;
  logic [DATA_WIDTH-1:0] mag;
  logic                  full;

  assign strobe = data_clk & ~data_clk_q;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    mag = data_in;
    if (data_in == MOST_NEG) begin
      mag = FULL_SCALE;
    end else if (data_in[DATA_WIDTH-1]) begin
      mag = $unsigned(-data_in);
    end
  end

  assign full = (mag == FULL_SCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_clk_q <= 1'b0;
      run_peak   <= '0;
      run_clip   <= 1'b0;
      cnt        <= '0;
    end else begin
      data_clk_q <= data_clk;
      if (clear) begin
        run_peak <= '0;
        run_clip <= 1'b0;
        cnt      <= '0;
      end else if (strobe) begin
        if (cnt_en) begin
          cnt <= cnt + 1'b1;
        end
        if (acc_en) begin
          if (mag > run_peak) begin
            run_peak <= mag;
          end
          if (full) begin
            run_clip <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cic_gain_ctrl.sv
// Windowed peak AGC for a CIC decimator: measure, decide one step, settle, repeat; manual override.
// Gain registers at the end of the one-cycle DECIDE state; manual gain lands one clk later.
module cic_gain_ctrl
  import cic_gain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int GAIN_WIDTH = 8,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int GAIN_INIT  = DEF_GAIN_INIT,
  parameter int GAIN_MAX   = DEF_GAIN_MAX,
  parameter int HI_THRESH  = DEF_HI_THRESH,
  parameter int LO_THRESH  = DEF_LO_THRESH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         manual_mode,
  input  logic        [GAIN_WIDTH-1:0] manual_gain,
  input  logic                         data_clk,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic        [GAIN_WIDTH-1:0] gain,
  output logic                         gain_update,
  output logic        [DATA_WIDTH-1:0] peak,
  output logic                         clip,
  output logic                         busy
);

  localparam int CNT_W = $clog2(max_int(WINDOW, SETTLE) + 1);

  localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]      SET_LAST = CNT_W'(SETTLE - 1);
  localparam logic [GAIN_WIDTH-1:0] G_INIT   = GAIN_WIDTH'(GAIN_INIT);
  localparam logic [GAIN_WIDTH-1:0] G_MAX    = GAIN_WIDTH'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0] G_ONE    = GAIN_WIDTH'(1);
  localparam logic [GAIN_WIDTH-1:0] G_TWO    = GAIN_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] HI_LVL   = DATA_WIDTH'(HI_THRESH);
  localparam logic [DATA_WIDTH-1:0] LO_LVL   = DATA_WIDTH'(LO_THRESH);

  state_t                  state_q, state_d;
  logic [GAIN_WIDTH-1:0]   gain_q, gain_d;
  logic                    strobe;
  logic [DATA_WIDTH-1:0]   run_peak;
  logic                    run_clip;
  logic [CNT_W-1:0]        cnt;
  logic                    clear;
  logic                    load_res;
  logic                    win_done;
  logic                    settle_done;

  cic_peak_detect #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_peak (
    .clk     (clk),
    .rst     (rst),
    .data_clk(data_clk),
    .data_in (data_in),
    .clear   (clear),
    .acc_en  (state_q == ST_MEASURE),
    .cnt_en  ((state_q == ST_MEASURE) || (state_q == ST_SETTLE)),
    .strobe  (strobe),
    .run_peak(run_peak),
    .run_clip(run_clip),
    .cnt     (cnt)
  );

  assign win_done    = strobe && (cnt == WIN_LAST);
  assign settle_done = strobe && (cnt == SET_LAST);

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    load_res = 1'b0;
    if (manual_mode) begin
      state_d = ST_IDLE;
      gain_d  = (manual_gain > G_MAX) ? G_MAX : manual_gain;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_MEASURE;
        ST_MEASURE: if (win_done) state_d = ST_DECIDE;
        ST_DECIDE: begin
          load_res = 1'b1;
          // A clipped window backs off twice as hard as a merely hot one.
          if (run_clip) begin
            gain_d = (gain_q >= G_TWO) ? (gain_q - G_TWO) : '0;
          end else if (run_peak >= HI_LVL) begin
            if (gain_q != '0) gain_d = gain_q - G_ONE;
          end else if (run_peak < LO_LVL) begin
            if (gain_q < G_MAX) gain_d = gain_q + G_ONE;
          end
          state_d = (gain_d != gain_q) ? ST_SETTLE : ST_MEASURE;
        end
        ST_SETTLE:  if (settle_done) state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Accumulators restart whenever a fresh measurement window is about to begin.
  assign clear = (state_q == ST_IDLE) || (state_q == ST_DECIDE) ||
                 ((state_q == ST_SETTLE) && settle_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gain_q      <= G_INIT;
      gain_update <= 1'b0;
      peak        <= '0;
      clip        <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      gain_update <= (gain_d != gain_q);
      if (load_res) begin
        peak <= run_peak;
        clip <= run_clip;
      end
    end
  end

  assign gain = gain_q;
  assign busy = (state_q != ST_IDLE);

endmodule
